// File: rtl/pe_row_responder_pkg.sv
// -----------------------------------------------------------------------------
// pe_row_responder_pkg
// Shared widths, FSM state encoding and arithmetic helpers for the PE row
// responder and its lane MAC.
// No ports (package).
// -----------------------------------------------------------------------------
package pe_row_responder_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int PARALLEL_WIDTH  = 128;
  localparam int PAR_LANES       = PARALLEL_WIDTH / DATA_WIDTH;
  localparam int LANE_SEL_WIDTH  = $clog2(PAR_LANES);
  localparam int ACT_INDEX_WIDTH = 4;
  localparam int WEI_INDEX_WIDTH = 5;
  localparam int PSUM_WIDTH      = 24;
  localparam int PROD_WIDTH      = 2 * DATA_WIDTH;
  localparam int WAIT_CYC        = 3;
  localparam int WAIT_CNT_WIDTH  = $clog2(WAIT_CYC + 1);

  // Counter value in the final mandatory wait cycle.
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } pe_state_e;

  // Sign-extend a full-precision product into the accumulator width.
  function automatic logic signed [PSUM_WIDTH-1:0] sext_prod(
    input logic signed [PROD_WIDTH-1:0] p
  );
    return {{(PSUM_WIDTH - PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
  endfunction

endpackage

// File: rtl/pe_row_responder_lane_mac.sv
// -----------------------------------------------------------------------------
// pe_lane_mac
// Lane select, signed multiply and wrap-around accumulate for one beat/cycle.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (clears accumulator)
//   beat         consume serial_in * lane[sel] this cycle
//   clear        start a new row: accumulate onto zero instead of acc
//   serial_in    signed serial operand
//   lanes        packed lane vector, lane 0 in LSBs
//   sel          lane select; values >= PAR_LANES select a zero operand
//   acc_next     accumulator value that will be registered at this edge
//   sel_bad      sel is out of range this cycle
// -----------------------------------------------------------------------------
module pe_lane_mac
  import pe_row_responder_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              beat,
  input  logic                              clear,
  input  logic signed [DATA_WIDTH-1:0]      serial_in,
  input  logic        [PARALLEL_WIDTH-1:0]  lanes,
  input  logic        [WEI_INDEX_WIDTH-1:0] sel,
  output logic signed [PSUM_WIDTH-1:0]      acc_next,
  output logic                              sel_bad
);

  logic signed [DATA_WIDTH-1:0] lane_arr [PAR_LANES];
  logic signed [DATA_WIDTH-1:0] lane_op;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PSUM_WIDTH-1:0] acc_q;
  logic signed [PSUM_WIDTH-1:0] acc_d;

  for (genvar g = 0; g < PAR_LANES; g++) begin : g_lane
    assign lane_arr[g] = lanes[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    sel_bad = (32'(sel) >= PAR_LANES);
    lane_op = sel_bad ? '0 : lane_arr[sel[LANE_SEL_WIDTH-1:0]];
    // Both operands widened first so the product keeps full signed precision.
    prod    = PROD_WIDTH'(serial_in) * PROD_WIDTH'(lane_op);
    acc_d   = acc_q;
    if (beat) begin
      acc_d = (clear ? '0 : acc_q) + sext_prod(prod);
    end
  end

  // ---- accumulator register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_next = acc_d;

endmodule

// File: rtl/pe_row_responder.sv
// -----------------------------------------------------------------------------
// pe_row_responder
// PE-side responder for the mem_controller read interface. Runs the sparse
// row MAC over en beats and returns the row handshake pulses; one signed
// partial sum per computed row leaves through a valid/ready port.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   mode                0: act-serial (done_0 per row), 1: weight-serial (done_0 per beat)
//   en                  beat valid
//   serial_out          signed serial operand
//   parallel_out        lane vector, lane 0 in LSBs
//   act_index           lane select in mode 1
//   wei_col_index       lane select in mode 0
//   row_val_num         beats in the row, sampled at row start
//   zero_flag           row carries no data
//   psum_ready          downstream accepts psum
//   row_finish_done_0   pulse: beat group done
//   row_finish_done_1   pulse: skipped row completed
//   row_cal_done        pulse: row fully computed
//   wait_state          mem_controller must hold the next row
//   psum, psum_valid    row sum and its pending flag
//   idx_err             sticky out-of-range lane select
// -----------------------------------------------------------------------------
module pe_row_responder
  import pe_row_responder_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              mode,
  input  logic                              en,
  input  logic signed [DATA_WIDTH-1:0]      serial_out,
  input  logic        [PARALLEL_WIDTH-1:0]  parallel_out,
  input  logic        [ACT_INDEX_WIDTH-1:0] act_index,
  input  logic        [WEI_INDEX_WIDTH-1:0] wei_col_index,
  input  logic        [ACT_INDEX_WIDTH-1:0] row_val_num,
  input  logic                              zero_flag,
  input  logic                              psum_ready,
  output logic                              row_finish_done_0,
  output logic                              row_finish_done_1,
  output logic                              row_cal_done,
  output logic                              wait_state,
  output logic signed [PSUM_WIDTH-1:0]      psum,
  output logic                              psum_valid,
  output logic                              idx_err
);

  pe_state_e                     state_q, state_d;
  logic                          mode_q, mode_d;
  logic [ACT_INDEX_WIDTH-1:0]    rem_q, rem_d;
  logic [WAIT_CNT_WIDTH-1:0]     wcnt_q, wcnt_d;
  logic                          done0_q, done0_d;
  logic                          done1_q, done1_d;
  logic                          cal_q, cal_d;
  logic                          wait_q, wait_d;
  logic signed [PSUM_WIDTH-1:0]  psum_q, psum_d;
  logic                          pv_q, pv_d;
  logic                          err_q, err_d;

  logic                          beat, clear, last, finish;
  logic                          accepting, mode_eff, slot_free;
  logic [WEI_INDEX_WIDTH-1:0]    sel;
  logic signed [PSUM_WIDTH-1:0]  acc_next;
  logic                          sel_bad;

  pe_lane_mac u_mac (
    .clk       (clk),
    .reset     (reset),
    .beat      (beat),
    .clear     (clear),
    .serial_in (serial_out),
    .lanes     (parallel_out),
    .sel       (sel),
    .acc_next  (acc_next),
    .sel_bad   (sel_bad)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    cal_d   = 1'b0;
    wait_d  = wait_q;
    psum_d  = psum_q;
    pv_d    = pv_q;
    err_d   = err_q;
    beat    = 1'b0;
    clear   = 1'b0;
    last    = 1'b0;
    finish  = 1'b0;

    // The DONE cycle accepts a new row exactly like IDLE does.
    accepting = (state_q == ST_IDLE) || (state_q == ST_DONE);
    mode_eff  = accepting ? mode : mode_q;
    sel       = mode_eff ? WEI_INDEX_WIDTH'(act_index) : wei_col_index;
    slot_free = !pv_q || psum_ready;

    if (pv_q && psum_ready) pv_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (en) begin
          if (zero_flag || (row_val_num == '0)) begin
            done1_d = 1'b1;
            cal_d   = 1'b1;
          end else begin
            mode_d  = mode;
            rem_d   = row_val_num;
            beat    = 1'b1;
            clear   = 1'b1;
            state_d = ST_MAC;
          end
        end
      end
      ST_MAC: begin
        if (en) beat = 1'b1;
      end
      ST_WAIT: begin
        if ((wcnt_q >= WAIT_LAST) && slot_free) finish = 1'b1;
        else if (wcnt_q < WAIT_LAST)            wcnt_d = wcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared beat bookkeeping for the first beat (from IDLE/DONE) and MAC beats.
    if (beat) begin
      if (mode_d)  done0_d = 1'b1;
      if (sel_bad) err_d   = 1'b1;
      if (rem_d == ACT_INDEX_WIDTH'(1)) last  = 1'b1;
      else                              rem_d = rem_d - 1'b1;
    end

    if (last) begin
      if (slot_free) begin
        finish = 1'b1;
      end else begin
        state_d = ST_WAIT;
        wait_d  = 1'b1;
        wcnt_d  = '0;
      end
    end

    if (finish) begin
      state_d = ST_DONE;
      wait_d  = 1'b0;
      cal_d   = 1'b1;
      if (!mode_d) done0_d = 1'b1;
      psum_d  = acc_next;
      pv_d    = 1'b1;
    end
  end

  // ---- control and output registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      cal_q   <= 1'b0;
      wait_q  <= 1'b0;
      psum_q  <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      cal_q   <= cal_d;
      wait_q  <= wait_d;
      psum_q  <= psum_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
    end
  end

  assign row_finish_done_0 = done0_q;
  assign row_finish_done_1 = done1_q;
  assign row_cal_done      = cal_q;
  assign wait_state        = wait_q;
  assign psum              = psum_q;
  assign psum_valid        = pv_q;
  assign idx_err           = err_q;

endmodule

// File: tb/tb_pe_row_responder.sv
module tb_pe_row_responder;
  import pe_row_responder_pkg::*;

  logic clk = 1'b0;
  logic reset, mode, en, zero_flag, psum_ready;
  logic signed [DATA_WIDTH-1:0]      serial_out;
  logic        [PARALLEL_WIDTH-1:0]  parallel_out;
  logic        [ACT_INDEX_WIDTH-1:0] act_index;
  logic        [WEI_INDEX_WIDTH-1:0] wei_col_index;
  logic        [ACT_INDEX_WIDTH-1:0] row_val_num;
  logic row_finish_done_0, row_finish_done_1, row_cal_done, wait_state;
  logic [PSUM_WIDTH-1:0] psum;
  logic psum_valid, idx_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run_cmp = 1'b0;

  pe_row_responder dut (
    .clk(clk), .reset(reset), .mode(mode), .en(en),
    .serial_out(serial_out), .parallel_out(parallel_out),
    .act_index(act_index), .wei_col_index(wei_col_index),
    .row_val_num(row_val_num), .zero_flag(zero_flag), .psum_ready(psum_ready),
    .row_finish_done_0(row_finish_done_0), .row_finish_done_1(row_finish_done_1),
    .row_cal_done(row_cal_done), .wait_state(wait_state),
    .psum(psum), .psum_valid(psum_valid), .idx_err(idx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural row model ----------------
  bit m_in_row, m_waiting, m_mode;
  int m_rem, m_sum, m_wait_cycles;
  logic m_done0, m_done1, m_cal, m_wait, m_pv, m_err;
  logic [PSUM_WIDTH-1:0] m_psum;

  function automatic int lane_val(input logic [PARALLEL_WIDTH-1:0] v, input int s);
    logic signed [7:0] b;
    if (s >= PAR_LANES) return 0;
    b = v[s*8 +: 8];
    return int'(b);
  endfunction

  task automatic finish_row();
    m_cal = 1'b1;
    if (!m_mode) m_done0 = 1'b1;
    m_psum = m_sum[PSUM_WIDTH-1:0];
    m_pv = 1'b1;
    m_wait = 1'b0;
    m_waiting = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin : model
    bit free;
    int s;
    if (reset) begin
      m_in_row = 0; m_waiting = 0; m_mode = 0; m_rem = 0; m_sum = 0; m_wait_cycles = 0;
      m_done0 = 0; m_done1 = 0; m_cal = 0; m_wait = 0; m_pv = 0; m_err = 0; m_psum = '0;
    end else begin
      free = !m_pv || psum_ready;
      m_done0 = 0; m_done1 = 0; m_cal = 0;
      if (m_pv && psum_ready) m_pv = 0;
      if (m_waiting) begin
        m_wait_cycles++;
        if (m_wait_cycles >= WAIT_CYC && free) finish_row();
      end else if (en) begin
        if (!m_in_row) begin
          if (zero_flag || row_val_num == 0) begin
            m_done1 = 1; m_cal = 1;
          end else begin
            m_in_row = 1; m_mode = mode; m_rem = int'(row_val_num); m_sum = 0;
          end
        end
        if (m_in_row) begin
          s = m_mode ? int'(act_index) : int'(wei_col_index);
          if (s >= PAR_LANES) m_err = 1;
          m_sum += int'(serial_out) * lane_val(parallel_out, s);
          if (m_mode) m_done0 = 1;
          m_rem--;
          if (m_rem == 0) begin
            m_in_row = 0;
            if (free) finish_row();
            else begin m_waiting = 1; m_wait_cycles = 0; m_wait = 1; end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset && run_cmp) begin
      chk("cyc_done0", 32'(row_finish_done_0), 32'(m_done0));
      chk("cyc_done1", 32'(row_finish_done_1), 32'(m_done1));
      chk("cyc_cal",   32'(row_cal_done),      32'(m_cal));
      chk("cyc_wait",  32'(wait_state),        32'(m_wait));
      chk("cyc_pv",    32'(psum_valid),        32'(m_pv));
      chk("cyc_psum",  32'(psum),              32'(m_psum));
      chk("cyc_err",   32'(idx_err),           32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input int e, input int s, input int ai, input int wi, input int rvn, input int zf);
    en = 1'(e); serial_out = 8'(s); act_index = 4'(ai); wei_col_index = 5'(wi);
    row_val_num = 4'(rvn); zero_flag = 1'(zf);
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
  endtask

  // Lanes 0..3 from arguments; lane 5 and lane 15 are decoys.
  function automatic logic [PARALLEL_WIDTH-1:0] mk_par(input int a0, input int a1, input int a2, input int a3);
    logic [PARALLEL_WIDTH-1:0] v;
    v = '0;
    v[7:0] = 8'(a0); v[15:8] = 8'(a1); v[23:16] = 8'(a2); v[31:24] = 8'(a3);
    v[47:40] = 8'h77; v[127:120] = 8'h05;
    return v;
  endfunction

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_done0"}, 32'(row_finish_done_0), 0);
    chk({pfx, "_done1"}, 32'(row_finish_done_1), 0);
    chk({pfx, "_cal"},   32'(row_cal_done), 0);
    chk({pfx, "_wait"},  32'(wait_state), 0);
    chk({pfx, "_pv"},    32'(psum_valid), 0);
    chk({pfx, "_psum"},  32'(psum), 0);
    chk({pfx, "_err"},   32'(idx_err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; mode = 0; en = 0; serial_out = '0; parallel_out = '0; act_index = '0;
    wei_col_index = '0; row_val_num = '0; zero_flag = 0; psum_ready = 1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 0;
    run_cmp = 1;
    idle();

    // mode 0: serial 1..7 on lane 2 (=3) -> 84
    mode = 0; parallel_out = mk_par(7, 1, 3, -2);
    for (int k = 1; k <= 7; k++) drv(1, k, 1, 2, 7, 0);
    chk("t1_cal", 32'(row_cal_done), 1);
    chk("t1_done0", 32'(row_finish_done_0), 1);
    chk("t1_psum", 32'(psum), 84);
    chk("t1_pv", 32'(psum_valid), 1);
    idle();

    // same row with a 2-cycle stall between beats 3 and 4
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) begin idle(); idle(); end
      drv(1, k, 1, 2, 7, 0);
    end
    chk("t2_cal", 32'(row_cal_done), 1);
    chk("t2_psum", 32'(psum), 84);
    idle();

    // zero row
    drv(1, 0, 0, 0, 5, 1);
    chk("t3_done1", 32'(row_finish_done_1), 1);
    chk("t3_cal", 32'(row_cal_done), 1);
    chk("t3_pv", 32'(psum_valid), 0);
    idle();

    // mode 1: three weights
    mode = 1; parallel_out = mk_par(-128, -128, 2, 9);
    drv(1, -128, 0, 3, 3, 0);
    chk("t4_d0a", 32'(row_finish_done_0), 1);
    drv(1, -128, 1, 3, 3, 0);
    chk("t4_d0b", 32'(row_finish_done_0), 1);
    chk("t4_cal_early", 32'(row_cal_done), 0);
    drv(1, 5, 2, 3, 3, 0);
    chk("t4_d0c", 32'(row_finish_done_0), 1);
    chk("t4_cal", 32'(row_cal_done), 1);
    chk("t4_psum", 32'(psum), 32778);
    idle();

    // back-pressure: row A pending, row B waits until ready
    mode = 0; parallel_out = mk_par(7, 1, 3, -2); psum_ready = 0;
    drv(1, 10, 0, 2, 2, 0);
    drv(1, 10, 0, 2, 2, 0);
    chk("t5_psumA", 32'(psum), 60);
    drv(1, 1, 0, 2, 2, 0);
    drv(1, 2, 0, 2, 2, 0);
    chk("t5_wait0", 32'(wait_state), 1);
    chk("t5_cal0", 32'(row_cal_done), 0);
    for (int i = 0; i < 5; i++) begin
      drv(1, 100, 0, 2, 2, 0);
      chk("t5_wait_hold", 32'(wait_state), 1);
    end
    psum_ready = 1;
    idle();
    chk("t5_wait_end", 32'(wait_state), 0);
    chk("t5_cal", 32'(row_cal_done), 1);
    chk("t5_psumB", 32'(psum), 9);
    chk("t5_pv", 32'(psum_valid), 1);
    // minimum wait length: ready returns at once, wait still lasts 3 cycles
    psum_ready = 0;
    drv(1, 4, 0, 2, 1, 0);
    psum_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_min_wait", 32'(wait_state), 1);
      idle();
    end
    chk("t5_min_end", 32'(wait_state), 0);
    chk("t5_psumC", 32'(psum), 12);
    idle();

    // reset during beat 4 of 7
    for (int k = 1; k <= 3; k++) drv(1, k, 0, 2, 7, 0);
    #2;
    en = 1; serial_out = 8'sd4; reset = 1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    #2;
    reset = 0; en = 0;
    @(negedge clk);
    for (int k = 1; k <= 7; k++) drv(1, k, 0, 2, 7, 0);
    chk("t6_psum", 32'(psum), 84);
    chk("t6_cal", 32'(row_cal_done), 1);
    idle();

    // out-of-range lane select
    drv(1, 5, 0, 17, 2, 0);
    chk("t7_err", 32'(idx_err), 1);
    drv(1, 1, 0, 2, 2, 0);
    chk("t7_psum", 32'(psum), 3);
    idle(); idle();
    chk("t7_err_sticky", 32'(idx_err), 1);

    run_cmp = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
